// File: rtl/counter_rmw_ctrl_if.sv
// Request/response handshake between a counter client and counter_rmw_ctrl.
// master = requester, slave = sequencer.
interface counter_rmw_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [DATA_WIDTH-1:0] req_val;
    logic                  resp_valid;
    logic [ADDR_WIDTH-1:0] resp_idx;
    logic [DATA_WIDTH-1:0] resp_old;
    logic [DATA_WIDTH-1:0] resp_new;
    logic                  resp_sat;

    modport master (
        output req_valid, req_op, req_idx, req_val,
        input  req_ready,
        input  resp_valid, resp_idx, resp_old, resp_new, resp_sat
    );

    modport slave (
        input  req_valid, req_op, req_idx, req_val,
        output req_ready,
        output resp_valid, resp_idx, resp_old, resp_new, resp_sat
    );
endinterface

// File: rtl/counter_rmw_ctrl.sv
// Read-modify-write sequencer for a 1W1R SRAM of saturating counters,
// with one-deep write forwarding and a post-reset init sweep.
module counter_rmw_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_rmw_ctrl_if.slave     bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam logic [DATA_WIDTH-1:0] CMAX = '1;
    localparam logic [1:0] OP_QUERY = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [1:0]            s1_op_q, s1_op_d;
    logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
    logic [DATA_WIDTH-1:0] s1_val_q, s1_val_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_idx_q, fwd_idx_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic [DATA_WIDTH-1:0] old_v;
    logic [DATA_WIDTH-1:0] new_v;
    logic                  sat_v;
    logic                  wr_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET;
            sweep_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_idx_q    <= '0;
            s1_val_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_idx_q    <= s1_idx_d;
            s1_val_q    <= s1_val_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_idx_q   <= fwd_idx_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // The array has not yet seen last cycle's write; take it from fwd.
    always_comb begin
        old_v = sram_dout1;
        if (fwd_valid_q && fwd_idx_q == s1_idx_q)
            old_v = fwd_data_q;
        new_v = old_v;
        sat_v = 1'b0;
        unique case (s1_op_q)
            OP_QUERY: new_v = old_v;
            OP_INC: begin
                sat_v = (old_v == CMAX);
                new_v = sat_v ? old_v : old_v + 1'b1;
            end
            OP_DEC: begin
                sat_v = (old_v == '0);
                new_v = sat_v ? old_v : old_v - 1'b1;
            end
            OP_SET:   new_v = s1_val_q;
            default:  new_v = old_v;
        endcase
        wr_v = (s1_op_q != OP_QUERY) && (new_v != old_v);
    end

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        s1_valid_d     = 1'b0;
        s1_op_d        = s1_op_q;
        s1_idx_d       = s1_idx_q;
        s1_val_d       = s1_val_q;
        fwd_valid_d    = 1'b0;
        fwd_idx_d      = fwd_idx_q;
        fwd_data_d     = fwd_data_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_idx   = '0;
        bus.resp_old   = '0;
        bus.resp_new   = '0;
        bus.resp_sat   = 1'b0;
        sram_csb0      = 1'b1;
        sram_addr0     = '0;
        sram_din0      = '0;
        sram_csb1      = 1'b1;
        sram_addr1     = '0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
            ST_INIT: begin
                sram_csb0  = 1'b0;
                sram_addr0 = sweep_q;
                sram_din0  = INIT_VAL;
                sweep_d    = sweep_q + 1'b1;
                if (&sweep_q)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    sram_csb1  = 1'b0;
                    sram_addr1 = bus.req_idx;
                    s1_valid_d = 1'b1;
                    s1_op_d    = bus.req_op;
                    s1_idx_d   = bus.req_idx;
                    s1_val_d   = bus.req_val;
                end
                if (s1_valid_q) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_idx   = s1_idx_q;
                    bus.resp_old   = old_v;
                    bus.resp_new   = new_v;
                    bus.resp_sat   = sat_v;
                    if (wr_v) begin
                        sram_csb0   = 1'b0;
                        sram_addr0  = s1_idx_q;
                        sram_din0   = new_v;
                        fwd_valid_d = 1'b1;
                        fwd_idx_d   = s1_idx_q;
                        fwd_data_d  = new_v;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign init_done = (state_q == ST_RUN);
endmodule

// File: tb/tb_counter_rmw_ctrl.sv
// Bench for counter_rmw_ctrl: read-first SRAM model, reference array
// and a response scoreboard.
module tb_counter_rmw_ctrl;
    localparam int AW = 8;
    localparam int DW = 3;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] old_v;
        logic [DW-1:0] new_v;
        logic          sat;
        logic          wr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1 = '0;

    counter_rmw_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    counter_rmw_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VAL  ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .init_done (init_done),
        .sram_csb0 (sram_csb0),
        .sram_addr0(sram_addr0),
        .sram_din0 (sram_din0),
        .sram_csb1 (sram_csb1),
        .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    // Read-first SRAM: same-address read/write on one negedge sees old data.
    logic [DW-1:0] mem [256];
    logic          rd_p = 1'b0, wr_p = 1'b0;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;

    initial for (int i = 0; i < 256; i++) mem[i] = 3'd5;

    always @(posedge clk) begin
        rd_p <= !sram_csb1;
        ra   <= sram_addr1;
        wr_p <= !sram_csb0;
        wa   <= sram_addr0;
        wd   <= sram_din0;
    end

    always @(negedge clk) begin
        if (rd_p) sram_dout1 <= mem[ra];
        if (wr_p) mem[wa] <= wd;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_cnt  = 0;
    bit   mon_en  = 1'b0;
    exp_t sb [$];
    logic [DW-1:0] ref_mem [256];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic samp();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] o, input logic [AW-1:0] i,
                         input logic [DW-1:0] v);
        exp_t e;
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = o;
        bus.req_idx   = i;
        bus.req_val   = v;
        old = ref_mem[i];
        case (o)
            2'd0:    nw = old;
            2'd1:    nw = (old == 3'd7) ? old : old + 3'd1;
            2'd2:    nw = (old == 3'd0) ? old : old - 3'd1;
            default: nw = v;
        endcase
        e.idx   = i;
        e.old_v = old;
        e.new_v = nw;
        e.sat   = (o == 2'd1 && old == 3'd7) || (o == 2'd2 && old == 3'd0);
        e.wr    = (o != 2'd0) && (nw != old);
        ref_mem[i] = nw;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    always begin
        exp_t e;
        samp();
        if (mon_en && !rst) begin
            if (!sram_csb0) wr_cnt++;
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_idx", bus.resp_idx, e.idx);
                    chk("resp_old", bus.resp_old, e.old_v);
                    chk("resp_new", bus.resp_new, e.new_v);
                    chk("resp_sat", bus.resp_sat, e.sat);
                    chk("wr_en", !sram_csb0, e.wr);
                    if (e.wr) begin
                        chk("wr_addr", sram_addr0, e.idx);
                        chk("wr_data", sram_din0, e.new_v);
                    end
                end
            end else begin
                chk("idle_csb0", sram_csb0, 1);
            end
        end
    end

    initial begin
        int  n;
        int  rds;
        bit  done;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        bus.req_val   = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        repeat (3) samp();
        chk("rst_csb0", sram_csb0, 1);
        chk("rst_csb1", sram_csb1, 1);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_resp", bus.resp_valid, 0);
        chk("rst_addr0", sram_addr0, 0);

        // Partial sweep, then reset at index 100.
        @(posedge clk);
        #1 rst = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            samp();
            if (!sram_csb0 && sram_addr0 == 8'd100) done = 1'b1;
        end
        chk("reach_idx100", done, 1);
        rst = 1'b1;
        #1;
        chk("midsweep_rst_csb0", sram_csb0, 1);
        chk("midsweep_rst_done", init_done, 0);
        idle(2);
        rst = 1'b0;

        // Full sweep.
        n    = 0;
        rds  = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            samp();
            if (init_done) begin
                done = 1'b1;
            end else begin
                if (!sram_csb1) rds++;
                if (!sram_csb0) begin
                    chk("sweep_addr", sram_addr0, n);
                    chk("sweep_din", sram_din0, 0);
                    n++;
                end
            end
        end
        chk("init_timeout", done, 1);
        chk("sweep_count", n, 256);
        chk("sweep_reads", rds, 0);
        chk("run_ready", bus.req_ready, 1);
        chk("run_csb0", sram_csb0, 1);
        mon_en = 1'b1;

        // inc idx 5 eight times back-to-back.
        wr_cnt = 0;
        for (int k = 0; k < 8; k++) drive(2'd1, 8'd5, 3'd0);
        idle(3);
        chk("inc5_writes", wr_cnt, 7);
        chk("inc5_final", mem[5], 7);

        // set 9 = 3 then dec 9 (forwarded), then query.
        drive(2'd3, 8'd9, 3'd3);
        drive(2'd2, 8'd9, 3'd0);
        idle(2);
        drive(2'd0, 8'd9, 3'd0);
        idle(3);
        chk("arr9", mem[9], 2);

        // dec idx 0 from 0.
        wr_cnt = 0;
        drive(2'd2, 8'd0, 3'd0);
        idle(3);
        chk("dec0_writes", wr_cnt, 0);

        // Interleaved inc 1, inc 2, inc 1, query 1.
        drive(2'd1, 8'd1, 3'd0);
        drive(2'd1, 8'd2, 3'd0);
        drive(2'd1, 8'd1, 3'd0);
        drive(2'd0, 8'd1, 3'd0);
        idle(3);
        chk("arr1", mem[1], 2);

        // Random traffic, half of it on a narrow index range.
        for (int k = 0; k < 10000; k++) begin
            logic [AW-1:0] ix;
            ix = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                             : AW'($urandom_range(0, 255));
            drive(2'($urandom_range(0, 3)), ix, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(4);
        chk("sb_empty", sb.size(), 0);
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) chk("final_array", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
